// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: store types, arbitration state and the muxed memory request.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_WIDTH = 11;
  localparam int unsigned DMEM_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } storetype_e;

  // In round-robin builds the same encoding names the port that wins the next contest.
  typedef enum logic {
    ST_P0_PRI = 1'b0,
    ST_P1_PRI = 1'b1
  } arb_state_e;

  // Storetype stays raw 3 bits so non-enumerated codes pass through to memory untouched.
  typedef struct packed {
    logic                       we;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [2:0]                 storetype;
    logic [DMEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// Signal names are seen from the arbiter: i_* flow into it, o_* flow out of it.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 32
);
  logic          i_p0_req;
  logic          i_p0_we;
  logic [AW-1:0] i_p0_addr;
  logic [2:0]    i_p0_storetype;
  logic [DW-1:0] i_p0_wdata;
  logic          o_p0_gnt;
  logic          o_p0_rvalid;
  logic [DW-1:0] o_p0_rdata;

  logic          i_p1_req;
  logic          i_p1_we;
  logic [AW-1:0] i_p1_addr;
  logic [2:0]    i_p1_storetype;
  logic [DW-1:0] i_p1_wdata;
  logic          o_p1_gnt;
  logic          o_p1_rvalid;
  logic [DW-1:0] o_p1_rdata;

  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [2:0]    o_mem_storetype;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  modport slave (
    input  i_p0_req, i_p0_we, i_p0_addr, i_p0_storetype, i_p0_wdata,
    output o_p0_gnt, o_p0_rvalid, o_p0_rdata,
    input  i_p1_req, i_p1_we, i_p1_addr, i_p1_storetype, i_p1_wdata,
    output o_p1_gnt, o_p1_rvalid, o_p1_rdata,
    output o_mem_we, o_mem_addr, o_mem_storetype, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_p0_req, i_p0_we, i_p0_addr, i_p0_storetype, i_p0_wdata,
    input  o_p0_gnt, o_p0_rvalid, o_p0_rdata,
    output i_p1_req, i_p1_we, i_p1_addr, i_p1_storetype, i_p1_wdata,
    input  o_p1_gnt, o_p1_rvalid, o_p1_rdata,
    input  o_mem_we, o_mem_addr, o_mem_storetype, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/dmem_arb_sel.sv
// Combinational winner select: an unopposed requester always wins, a contest goes to the port named by state.
module dmem_arb_sel
  import dmem_pkg::*;
(
  input  logic       p0_req_i,
  input  logic       p1_req_i,
  input  arb_state_e state_i,
  output logic       p0_gnt_o,
  output logic       p1_gnt_o
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    p0_gnt_o = 1'b0;
    p1_gnt_o = 1'b0;
    if (p0_req_i && p1_req_i) begin
      if (state_i == ST_P1_PRI) p1_gnt_o = 1'b1;
      else                      p0_gnt_o = 1'b1;
    end else begin
      p0_gnt_o = p0_req_i;
      p1_gnt_o = p1_req_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory with 1-cycle registered read return.
// Define DMEM_ARB_RR_EN for round-robin contests; otherwise fixed p0 priority with p1 starvation bound.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned P_ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int unsigned P_DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int unsigned P_STARVE_LIMIT = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  dmem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       sel_p0_gnt, sel_p1_gnt;
  logic       p0_gnt, p1_gnt;
  logic       p0_rd, p1_rd;
  mem_req_t   p0_req_s, p1_req_s, mem_req_s;

  logic                    p0_rvalid_q, p1_rvalid_q;
  logic [P_DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;

  dmem_arb_sel u_sel (
    .p0_req_i (bus.i_p0_req),
    .p1_req_i (bus.i_p1_req),
    .state_i  (state_q),
    .p0_gnt_o (sel_p0_gnt),
    .p1_gnt_o (sel_p1_gnt)
  );

  // Outputs read as zero for the whole reset window, combinational ones included.
  assign p0_gnt = sel_p0_gnt & i_rst_n;
  assign p1_gnt = sel_p1_gnt & i_rst_n;
  assign p0_rd  = p0_gnt & ~bus.i_p0_we;
  assign p1_rd  = p1_gnt & ~bus.i_p1_we;

  assign p0_req_s = '{we: bus.i_p0_we, addr: bus.i_p0_addr,
                      storetype: bus.i_p0_storetype, wdata: bus.i_p0_wdata};
  assign p1_req_s = '{we: bus.i_p1_we, addr: bus.i_p1_addr,
                      storetype: bus.i_p1_storetype, wdata: bus.i_p1_wdata};

  always_comb begin
    mem_req_s    = p0_req_s;
    mem_req_s.we = 1'b0;
    if (!i_rst_n)    mem_req_s = '0;
    else if (p1_gnt) mem_req_s = p1_req_s;
    else if (p0_gnt) mem_req_s = p0_req_s;
  end

  assign bus.o_mem_we        = mem_req_s.we;
  assign bus.o_mem_addr      = mem_req_s.addr;
  assign bus.o_mem_storetype = mem_req_s.storetype;
  assign bus.o_mem_wdata     = mem_req_s.wdata;

  assign bus.o_p0_gnt    = p0_gnt;
  assign bus.o_p1_gnt    = p1_gnt;
  assign bus.o_p0_rvalid = p0_rvalid_q;
  assign bus.o_p1_rvalid = p1_rvalid_q;
  assign bus.o_p0_rdata  = p0_rdata_q;
  assign bus.o_p1_rdata  = p1_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_rvalid_q <= p0_rd;
      p1_rvalid_q <= p1_rd;
      if (p0_rd) p0_rdata_q <= bus.i_mem_rdata;
      if (p1_rd) p1_rdata_q <= bus.i_mem_rdata;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_P0_PRI;
    else          state_q <= state_d;
  end

  // The port that just won yields the next contest to the other one.
  always_comb begin
    state_d = state_q;
    if (p0_gnt)      state_d = ST_P1_PRI;
    else if (p1_gnt) state_d = ST_P0_PRI;
  end
`else
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_P0_PRI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_P0_PRI: begin
        if (!bus.i_p1_req) begin
          cnt_d = '0;
        end else if (p0_gnt) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(P_STARVE_LIMIT)) state_d = ST_P1_PRI;
        end
      end
      ST_P1_PRI: begin
        if (p1_gnt || !bus.i_p1_req) begin
          state_d = ST_P0_PRI;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_P0_PRI;
        cnt_d   = '0;
      end
    endcase
  end
`endif

  // A waiting requester may withdraw, but must not alter its fields while still asking.
  a_p0_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bus.i_p0_req && !bus.o_p0_gnt) |=> (!bus.i_p0_req ||
      $stable({bus.i_p0_we, bus.i_p0_addr, bus.i_p0_storetype, bus.i_p0_wdata})));
  a_p1_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bus.i_p1_req && !bus.o_p1_gnt) |=> (!bus.i_p1_req ||
      $stable({bus.i_p1_we, bus.i_p1_addr, bus.i_p1_storetype, bus.i_p1_wdata})));
  a_one_gnt: assert property (@(posedge i_clk) !(bus.o_p0_gnt && bus.o_p1_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-lane memory behind the mux.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_STARVE_LIMIT(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [2:0] st);
    case (st)
      3'b000:  return {old_w[31:8], new_w[7:0]};
      3'b001:  return {old_w[31:16], new_w[15:0]};
      default: return new_w;
    endcase
  endfunction

  assign bus.i_mem_rdata = mem[bus.o_mem_addr];

  always @(posedge clk)
    if (bus.o_mem_we) mem[bus.o_mem_addr] <= merge(mem[bus.o_mem_addr], bus.o_mem_wdata, bus.o_mem_storetype);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p0(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [2:0] st, input logic [DW-1:0] wd);
    bus.i_p0_req = req; bus.i_p0_we = we; bus.i_p0_addr = addr;
    bus.i_p0_storetype = st; bus.i_p0_wdata = wd;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [2:0] st, input logic [DW-1:0] wd);
    bus.i_p1_req = req; bus.i_p1_we = we; bus.i_p1_addr = addr;
    bus.i_p1_storetype = st; bus.i_p1_wdata = wd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    {62'd0, bus.o_p1_gnt, bus.o_p0_gnt}, 64'd0);
    check({tag, "_rvalid"}, {62'd0, bus.o_p1_rvalid, bus.o_p0_rvalid}, 64'd0);
    check({tag, "_rdata"},  {bus.o_p1_rdata, bus.o_p0_rdata}, 64'd0);
    check({tag, "_mem"},    {18'd0, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_storetype, bus.o_mem_wdata}, 64'd0);
  endtask

  // Expected grant pattern for the contest run, as {p1_gnt, p0_gnt}.
  logic [1:0] exp_gnt [0:14];

  initial begin
    drive_p0(1'b0, 1'b0, '0, 3'b000, '0);
    drive_p1(1'b0, 1'b0, '0, 3'b000, '0);

    // Reset state with idle requesters.
    step(); step();
    @(negedge clk);
    check_all_zero("reset");
    step();
    rst_n = 1'b1;

    // Solo p0 write then read of the same word, back to back.
    drive_p0(1'b1, 1'b1, 11'h005, ST_SW, 32'hDEADBEEF);
    @(negedge clk);
    check("p0_wr_gnt",   {62'd0, bus.o_p1_gnt, bus.o_p0_gnt}, 64'b01);
    check("p0_wr_mem",   {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata}, {1'b1, 11'h005, 32'hDEADBEEF});
    step();
    drive_p0(1'b1, 1'b0, 11'h005, ST_SW, 32'h0);
    @(negedge clk);
    check("p0_rd_gnt",   {62'd0, bus.o_p1_gnt, bus.o_p0_gnt}, 64'b01);
    check("p0_rd_we",    {63'd0, bus.o_mem_we}, 64'd0);
    check("p0_wr_norv",  {63'd0, bus.o_p0_rvalid}, 64'd0);
    step();
    drive_p0(1'b0, 1'b0, '0, 3'b000, '0);
    @(negedge clk);
    check("p0_rvalid",   {62'd0, bus.o_p1_rvalid, bus.o_p0_rvalid}, 64'b01);
    check("p0_rdata",    {32'd0, bus.o_p0_rdata}, {32'd0, 32'hDEADBEEF});
    check("idle_mem",    {bus.o_mem_we, bus.o_mem_addr}, 64'd0);
    step();
    @(negedge clk);
    check("p0_rv_drop",  {63'd0, bus.o_p0_rvalid}, 64'd0);
    check("p0_rd_hold",  {32'd0, bus.o_p0_rdata}, {32'd0, 32'hDEADBEEF});

    // p1: store word, overwrite low byte, read back.
    drive_p1(1'b1, 1'b1, 11'h010, ST_SW, 32'h11223344);
    step();
    drive_p1(1'b1, 1'b1, 11'h010, ST_SB, 32'h000000AA);
    @(negedge clk);
    check("p1_sb_mem",   {bus.o_mem_we, bus.o_mem_storetype, bus.o_mem_addr}, {1'b1, 3'b000, 11'h010});
    step();
    drive_p1(1'b1, 1'b0, 11'h010, ST_SW, 32'h0);
    @(negedge clk);
    check("p1_rd_gnt",   {62'd0, bus.o_p1_gnt, bus.o_p0_gnt}, 64'b10);
    step();
    drive_p1(1'b0, 1'b0, '0, 3'b000, '0);
    @(negedge clk);
    check("p1_rvalid",   {62'd0, bus.o_p1_rvalid, bus.o_p0_rvalid}, 64'b10);
    check("p1_sb_data",  {32'd0, bus.o_p1_rdata}, {32'd0, 32'h112233AA});
    step();

    // Contested reads: p0 at 0x005, p1 at 0x010, both held.
    drive_p0(1'b1, 1'b0, 11'h005, ST_SW, 32'h0);
    drive_p1(1'b1, 1'b0, 11'h010, ST_SW, 32'h0);
`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rr_gnt_%0d", i), {62'd0, bus.o_p1_gnt, bus.o_p0_gnt},
            (i % 2 == 0) ? 64'b01 : 64'b10);
      step();
    end
`else
    for (int i = 0; i < 15; i++) exp_gnt[i] = 2'b01;
    exp_gnt[4]  = 2'b10;
    exp_gnt[14] = 2'b10;
    for (int i = 0; i < 15; i++) begin
      if (i == 9)  bus.i_p1_req = 1'b0;
      if (i == 10) bus.i_p1_req = 1'b1;
      @(negedge clk);
      check($sformatf("starve_gnt_%0d", i), {62'd0, bus.o_p1_gnt, bus.o_p0_gnt}, {62'd0, exp_gnt[i]});
      if (i == 4) check("starve_p1_addr", {53'd0, bus.o_mem_addr}, 64'h010);
      if (i == 5) begin
        check("starve_p1_rv", {62'd0, bus.o_p1_rvalid, bus.o_p0_rvalid}, 64'b10);
        check("starve_p1_rd", {32'd0, bus.o_p1_rdata}, {32'd0, 32'h112233AA});
      end
      step();
    end
`endif
    drive_p1(1'b0, 1'b0, '0, 3'b000, '0);
    step();
    step();

    // Reset asserted while a p0 read is being granted.
    drive_p0(1'b1, 1'b0, 11'h005, ST_SW, 32'h0);
    @(negedge clk);
    check("pre_rst_gnt", {62'd0, bus.o_p1_gnt, bus.o_p0_gnt}, 64'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    step();
    drive_p0(1'b0, 1'b0, '0, 3'b000, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rv0", {62'd0, bus.o_p1_rvalid, bus.o_p0_rvalid}, 64'd0);
    step();
    @(negedge clk);
    check("post_rst_rv1", {62'd0, bus.o_p1_rvalid, bus.o_p0_rvalid}, 64'd0);
    check("post_rst_rd",  {32'd0, bus.o_p0_rdata}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
